// File: rtl/lse_add_pipe.sv
// lse_add_pipe: 3-stage log-sum-exp adder, max(a,b) + log2(1 + 2^-|a-b|), full-width or packed lanes.
// Optional saturation event counter behind `LSE_ADD_PIPE_SAT_CNT_EN.
module lse_add_pipe #(
  parameter int P_WIDTH        = 24,
  parameter int P_FRAC_BITS    = 10,
  parameter int P_LUT_INT_BITS = 3,
  parameter int P_LUT_ADDR_W   = 6,
  parameter int P_LANES        = 4,
  parameter int P_LANE_FRAC    = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [P_WIDTH-1:0]        i_operand_a,
  input  logic [P_WIDTH-1:0]        i_operand_b,
  input  logic [1:0]                i_pe_mode,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [P_WIDTH-1:0]        o_sum,
  output logic                      o_sat,
  input  logic                      i_lut_we,
  input  logic [P_LUT_ADDR_W-1:0]   i_lut_addr,
  input  logic [P_FRAC_BITS:0]      i_lut_data
`ifdef LSE_ADD_PIPE_SAT_CNT_EN
  ,
  input  logic                      i_sat_clr,
  output logic [15:0]               o_sat_cnt
`endif
);
  localparam int LW = P_WIDTH / P_LANES;
  localparam int IB = P_FRAC_BITS + P_LUT_INT_BITS;
  localparam int RW = IB - P_LUT_ADDR_W;
  localparam int LV = P_FRAC_BITS + 1;
  localparam int PW = LV + RW + 2;
  localparam logic [P_WIDTH-1:0] NEG_INF = {1'b1, {(P_WIDTH-1){1'b0}}};
  localparam logic [P_WIDTH-1:0] POS_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic [LW-1:0] LANE_INF = {1'b1, {(LW-1){1'b0}}};
  localparam logic [LW-1:0] LANE_MAX = {1'b0, {(LW-1){1'b1}}};
  localparam logic [LW-1:0] LANE_ONE = LW'(1) << P_LANE_FRAC;

  logic adv;
  logic [LV-1:0] lut [2**P_LUT_ADDR_W];
  logic s1_v, s1_pk;
  logic [P_WIDTH-1:0] s1_a, s1_b;
  logic s2_v, s2_pk, s2_zero;
  logic [P_WIDTH-1:0] s2_max;
  logic [LV-1:0] s2_l0, s2_l1;
  logic [RW-1:0] s2_r;
  logic [P_LANES-1:0] s2_inc;
  logic [P_WIDTH-1:0] f_max, f_min, d, p_max;
  logic [P_LUT_ADDR_W-1:0] k, k1;
  logic f_zero;
  logic [P_LANES-1:0] p_inc;
  logic [LW-1:0] la, lb, lm;
  logic signed [LV:0] diff;
  logic signed [PW-1:0] prod, cw;
  logic [P_WIDTH:0] f_sum;
  logic f_sat, p_sat;
  logic [P_WIDTH-1:0] f_res, p_res;
  logic [LW:0] ls;

  assign adv = !o_out_valid || i_out_ready;
  assign o_in_ready = adv;

  always_comb begin
    f_max = $signed(s1_a) > $signed(s1_b) ? s1_a : s1_b;
    f_min = $signed(s1_a) > $signed(s1_b) ? s1_b : s1_a;
    d = f_max - f_min;
    k = d[IB-1 -: P_LUT_ADDR_W];
    k1 = &k ? k : k + P_LUT_ADDR_W'(1);
    f_zero = s1_a == NEG_INF || s1_b == NEG_INF || (d >> IB) != '0;
    p_max = '0;
    p_inc = '0;
    la = '0;
    lb = '0;
    lm = '0;
    for (int i = 0; i < P_LANES; i++) begin
      la = s1_a[i*LW +: LW];
      lb = s1_b[i*LW +: LW];
      lm = $signed(la) > $signed(lb) ? la : lb;
      p_max[i*LW +: LW] = lm;
      p_inc[i] = la != LANE_INF && lb != LANE_INF && (lm - (lm == la ? lb : la)) < LANE_ONE;
    end
  end

  // linear interpolation between neighbouring LUT entries, residual scaled by 2^-RW
  always_comb begin
    diff = $signed({1'b0, s2_l1}) - $signed({1'b0, s2_l0});
    prod = PW'(diff) * PW'($signed({1'b0, s2_r}));
    cw = $signed(PW'({1'b0, s2_l0})) + (prod >>> RW);
    f_sum = {s2_max[P_WIDTH-1], s2_max} + (s2_zero ? '0 : (P_WIDTH+1)'(cw));
    f_sat = !f_sum[P_WIDTH] && f_sum[P_WIDTH-1];
    f_res = f_sat ? POS_MAX : f_sum[P_WIDTH-1:0];
    p_res = '0;
    p_sat = 1'b0;
    ls = '0;
    for (int i = 0; i < P_LANES; i++) begin
      ls = {s2_max[i*LW+LW-1], s2_max[i*LW +: LW]} + (LW+1)'(s2_inc[i]);
      p_res[i*LW +: LW] = (!ls[LW] && ls[LW-1]) ? LANE_MAX : ls[LW-1:0];
      p_sat = p_sat | (!ls[LW] && ls[LW-1]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v <= 1'b0;
      s1_pk <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s2_v <= 1'b0;
      s2_pk <= 1'b0;
      s2_zero <= 1'b0;
      s2_max <= '0;
      s2_l0 <= '0;
      s2_l1 <= '0;
      s2_r <= '0;
      s2_inc <= '0;
      o_out_valid <= 1'b0;
      o_sum <= '0;
      o_sat <= 1'b0;
    end else if (adv) begin
      s1_v <= i_in_valid;
      s1_pk <= |i_pe_mode;
      s1_a <= i_operand_a;
      s1_b <= i_operand_b;
      s2_v <= s1_v;
      s2_pk <= s1_pk;
      s2_zero <= f_zero;
      s2_max <= s1_pk ? p_max : f_max;
      s2_l0 <= lut[k];
      s2_l1 <= lut[k1];
      s2_r <= d[RW-1:0];
      s2_inc <= p_inc;
      o_out_valid <= s2_v;
      if (s2_v) begin
        o_sum <= s2_pk ? p_res : f_res;
        o_sat <= s2_pk ? p_sat : f_sat;
      end
    end
  end

  // writes land at the clock edge, so a same-cycle S2 read still sees the old entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**P_LUT_ADDR_W; i++) lut[i] <= '0;
    end else if (i_lut_we) begin
      lut[i_lut_addr] <= i_lut_data;
    end
  end

`ifdef LSE_ADD_PIPE_SAT_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_sat_cnt <= '0;
    else if (i_sat_clr) o_sat_cnt <= '0;
    else if (o_out_valid && i_out_ready && o_sat && o_sat_cnt != 16'hFFFF) o_sat_cnt <= o_sat_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_lse_add_pipe.sv
// tb_lse_add_pipe: directed and randomized checks of lse_add_pipe against an arithmetic reference model.
module tb_lse_add_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, sat, lut_we = 1'b0;
  logic [23:0] a = '0, b = '0, sum;
  logic [1:0] mode = '0;
  logic [5:0] lut_addr = '0;
  logic [10:0] lut_data = '0;
  int checks = 0, failures = 0;
  int lut_m[64];
  logic [24:0] expq[$];
  logic [24:0] hold_v, e;
  bit held, acc;
  int got_n, idx;
  logic [23:0] oa[20], ob[20];
  logic [1:0] om[20];
  logic [23:0] t;

  always #5 clk = ~clk;

  lse_add_pipe dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_operand_a(a), .i_operand_b(b), .i_pe_mode(mode), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_sum(sum), .o_sat(sat), .i_lut_we(lut_we),
    .i_lut_addr(lut_addr), .i_lut_data(lut_data)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [24:0] model(input logic [23:0] x, input logic [23:0] y, input logic [1:0] m);
    int p, q, mx, mn, dd, k, k1, s, corr;
    logic [23:0] res;
    logic st;
    res = '0;
    st = 1'b0;
    if (m == 2'd0) begin
      p = $signed(x);
      q = $signed(y);
      mx = p > q ? p : q;
      mn = p > q ? q : p;
      dd = mx - mn;
      corr = 0;
      if (x != 24'h800000 && y != 24'h800000 && dd < 8 * 1024) begin
        k = dd / 128;
        k1 = (k == 63) ? k : k + 1;
        corr = lut_m[k] + (((lut_m[k1] - lut_m[k]) * (dd % 128)) >>> 7);
      end
      s = mx + corr;
      if (s > 8388607) begin
        res = 24'h7FFFFF;
        st = 1'b1;
      end else res = 24'(s);
    end else begin
      for (int j = 0; j < 4; j++) begin
        p = $signed(x[j*6 +: 6]);
        q = $signed(y[j*6 +: 6]);
        mx = p > q ? p : q;
        mn = p > q ? q : p;
        s = mx + ((p != -32 && q != -32 && mx - mn < 2) ? 1 : 0);
        if (s > 31) begin
          s = 31;
          st = 1'b1;
        end
        res[j*6 +: 6] = 6'(s);
      end
    end
    return {st, res};
  endfunction

  task automatic lut_wr(input int ad, input int dv);
    lut_we = 1'b1;
    lut_addr = 6'(ad);
    lut_data = 11'(dv);
    @(posedge clk); #1;
    lut_we = 1'b0;
    lut_m[ad] = dv;
  endtask

  task automatic one_op(input string name, input logic [23:0] x, input logic [23:0] y,
                        input logic [1:0] m, input logic [23:0] es, input logic es_sat);
    int n;
    a = x; b = y; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_lat"}, n, 3);
    check({name, "_sum"}, sum, es);
    check({name, "_sat"}, sat, es_sat);
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (held && out_valid) check("stall_hold", {sat, sum}, hold_v);
    held = out_valid && !out_ready;
    hold_v = {sat, sum};
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      got_n++;
      check("stream_avail", 32'(expq.size() > 0), 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("stream_res", {sat, sum}, e);
      end
    end
    if (acc) expq.push_back(model(a, b, mode));
    @(posedge clk); #1;
  endtask

  initial begin
    foreach (lut_m[i]) lut_m[i] = 0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_sat", sat, 0);
    check("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lut_wr(0, 'h400);
    one_op("two_ones", 24'h000400, 24'h000400, 2'd0, 24'h000800, 1'b0);
    one_op("a_neginf", 24'h800000, 24'h001234, 2'd0, 24'h001234, 1'b0);
    one_op("both_neginf", 24'h800000, 24'h800000, 2'd0, 24'h800000, 1'b0);
    one_op("full_sat", 24'h7FFF00, 24'h7FFF00, 2'd0, 24'h7FFFFF, 1'b1);
    one_op("out_of_lut", 24'h002000, 24'h000000, 2'd0, 24'h002000, 1'b0);
    one_op("pk_equal", 24'h104104, 24'h104104, 2'd1, 24'h145145, 1'b0);
    one_op("pk_neginf", 24'h104120, 24'h104103, 2'd2, 24'h145143, 1'b0);
    one_op("pk_sat", 24'h7DF7DF, 24'h7DF7DF, 2'd3, 24'h7DF7DF, 1'b1);

    for (int i = 0; i < 64; i++) lut_wr(i, $urandom_range(0, 1024));
    for (int i = 0; i < 20; i++) begin
      om[i] = ($urandom % 2 == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      oa[i] = 24'($urandom);
      if (om[i] == 2'd0) begin
        if ($urandom % 4 == 0) oa[i][23:12] = 12'h7FF;
        ob[i] = oa[i] + 24'($urandom_range(0, 9000));
      end else begin
        ob[i] = oa[i];
        for (int j = 0; j < 4; j++) ob[i][j*6 +: 6] = oa[i][j*6 +: 6] + 6'($urandom_range(0, 2));
      end
      if ($urandom % 2 == 1) begin
        t = oa[i]; oa[i] = ob[i]; ob[i] = t;
      end
      if ($urandom % 6 == 0) oa[i] = 24'h800000;
      if ($urandom % 6 == 0) ob[i] = 24'h800000;
    end
    held = 1'b0;
    got_n = 0;
    idx = 0;
    for (int c = 0; c < 600 && got_n < 20; c++) begin
      in_valid = idx < 20;
      if (idx < 20) begin
        a = oa[idx]; b = ob[idx]; mode = om[idx];
      end
      out_ready = ($urandom % 2 == 0);
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", got_n, 20);
    check("stream_left", expq.size(), 0);

    lut_wr(5, 'h100);
    a = 24'h000280; b = 24'h0; mode = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    lut_we = 1'b1; lut_addr = 6'd5; lut_data = 11'h200;
    @(posedge clk); #1;
    in_valid = 1'b0; lut_we = 1'b0; lut_m[5] = 'h200;
    @(posedge clk); #1;
    check("lut_same_cycle_old", {out_valid, sum}, {1'b1, 24'h000380});
    @(posedge clk); #1;
    check("lut_same_cycle_new", {out_valid, sum}, {1'b1, 24'h000480});
    @(posedge clk); #1;

    lut_wr(0, 'h3FF);
    a = 24'h000400; b = 24'h000400; mode = 2'd0; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (lut_m[i]) lut_m[i] = 0;
    one_op("post_rst_l0", 24'h000400, 24'h000400, 2'd0, 24'h000400, 1'b0);
    one_op("post_rst_l5", 24'h000280, 24'h000000, 2'd0, 24'h000280, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
